// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer: state encoding and count width.
package countdown_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bits needed to hold every value 0..max_cnt.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot or auto-reload expiry and abort.
// Optional COUNTDOWN_TIMER_PAUSE_EN adds i_pause to freeze counting in RUN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned MAX_CNT = 32,
  parameter bit          LOOP    = 1'b1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_load_valid,
  input  logic [cnt_width(MAX_CNT)-1:0]    i_load_val,
  output logic                             o_load_ready,
  input  logic                             i_abort,
`ifdef COUNTDOWN_TIMER_PAUSE_EN
  input  logic                             i_pause,
`endif
  output logic [cnt_width(MAX_CNT)-1:0]    o_cnt,
  output logic                             o_done,
  output logic                             o_busy,
  output logic                             o_expired
);

  localparam int unsigned W     = cnt_width(MAX_CNT);
  localparam logic [W-1:0] MAX_V = W'(MAX_CNT);

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           done_q, done_d;
  logic           busy_q, expired_q, ready_q;
  logic [W-1:0]   load_sat_c;
  logic           pause_c;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
  assign pause_c = i_pause;
`else
  assign pause_c = 1'b0;
`endif

  assign load_sat_c = (i_load_val > MAX_V) ? MAX_V : i_load_val;

  // Next-state: abort beats expiry and load; loads only outside RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!pause_c) begin
          if (cnt_q == W'(1)) begin
            done_d = 1'b1;
            if (LOOP) begin
              cnt_d = reload_q;
            end else begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
          end
        end
      end
      default: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_load_valid) begin
          cnt_d    = load_sat_c;
          reload_d = load_sat_c;
          if (load_sat_c == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      busy_q    <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
      ready_q   <= (state_d != ST_RUN);
    end
  end

  assign o_cnt        = cnt_q;
  assign o_done       = done_q;
  assign o_busy       = busy_q;
  assign o_expired    = expired_q;
  assign o_load_ready = ready_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one-shot and auto-reload instances on shared stimulus.
module tb_countdown_timer;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_v = 1'b0;
  logic [5:0] ld_val = '0;
  logic       ab = 1'b0;
  logic       pause = 1'b0;

  logic [5:0] cnt0, cnt1;
  logic       rdy0, rdy1, done0, done1, busy0, busy1, exp0, exp1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer #(.MAX_CNT(32), .LOOP(1'b0)) dut_os (
    .i_clk(clk), .i_rst(rst), .i_load_valid(ld_v), .i_load_val(ld_val),
    .o_load_ready(rdy0), .i_abort(ab),
`ifdef COUNTDOWN_TIMER_PAUSE_EN
    .i_pause(pause),
`endif
    .o_cnt(cnt0), .o_done(done0), .o_busy(busy0), .o_expired(exp0)
  );

  countdown_timer #(.MAX_CNT(32), .LOOP(1'b1)) dut_lp (
    .i_clk(clk), .i_rst(rst), .i_load_valid(ld_v), .i_load_val(ld_val),
    .o_load_ready(rdy1), .i_abort(ab),
`ifdef COUNTDOWN_TIMER_PAUSE_EN
    .i_pause(pause),
`endif
    .o_cnt(cnt1), .o_done(done1), .o_busy(busy1), .o_expired(exp1)
  );

  // Reference: timer described by load edge and period, count derived arithmetically.
  int m_mode[2];
  int m_tl[2];
  int m_n[2];
  bit m_done[2];
  int cyc = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = MODE_IDLE;
      m_done[i] = 1'b0;
      m_tl[i] = 0;
      m_n[i] = 1;
    end
  endfunction

  function automatic void model_step();
    int sat;
    int el;
    cyc++;
    sat = (int'(ld_val) > 32) ? 32 : int'(ld_val);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (m_mode[i] == MODE_RUN) begin
        if (ab) begin
          m_mode[i] = MODE_IDLE;
        end else begin
          el = cyc - m_tl[i];
          if (el % m_n[i] == 0) begin
            m_done[i] = 1'b1;
            if (i == 0) m_mode[i] = MODE_DONE;
          end
        end
      end else if (ab) begin
        m_mode[i] = MODE_IDLE;
      end else if (ld_v) begin
        if (sat == 0) begin
          m_mode[i] = MODE_DONE;
          m_done[i] = 1'b1;
        end else begin
          m_mode[i] = MODE_RUN;
          m_tl[i] = cyc;
          m_n[i] = sat;
        end
      end
    end
  endfunction

  function automatic int model_cnt(input int i);
    if (m_mode[i] != MODE_RUN) return 0;
    return m_n[i] - ((cyc - m_tl[i]) % m_n[i]);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cnt_os"}, int'(cnt0), 0);
    chk({tag, " cnt_lp"}, int'(cnt1), 0);
    chk({tag, " done_os"}, int'(done0), 0);
    chk({tag, " done_lp"}, int'(done1), 0);
    chk({tag, " busy_os"}, int'(busy0), 0);
    chk({tag, " busy_lp"}, int'(busy1), 0);
    chk({tag, " exp_os"}, int'(exp0), 0);
    chk({tag, " exp_lp"}, int'(exp1), 0);
    chk({tag, " rdy_os"}, int'(rdy0), 1);
    chk({tag, " rdy_lp"}, int'(rdy1), 1);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " cnt_os"}, int'(cnt0), model_cnt(0));
    chk({tag, " cnt_lp"}, int'(cnt1), model_cnt(1));
    chk({tag, " done_os"}, int'(done0), int'(m_done[0]));
    chk({tag, " done_lp"}, int'(done1), int'(m_done[1]));
    chk({tag, " busy_os"}, int'(busy0), int'(m_mode[0] == MODE_RUN));
    chk({tag, " busy_lp"}, int'(busy1), int'(m_mode[1] == MODE_RUN));
    chk({tag, " exp_os"}, int'(exp0), int'(m_mode[0] == MODE_DONE));
    chk({tag, " exp_lp"}, int'(exp1), int'(m_mode[1] == MODE_DONE));
    chk({tag, " rdy_os"}, int'(rdy0), int'(m_mode[0] != MODE_RUN));
    chk({tag, " rdy_lp"}, int'(rdy1), int'(m_mode[1] != MODE_RUN));
  endtask

  typedef struct {
    bit v; int val; bit ab;
    int c0; bit d0; bit e0;
    int c1; bit d1; bit e1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Directed table: one-shot countdown, saturation, zero load, abort, ignored load.
    tbl.push_back('{1,  5, 0,  5, 0, 0,  5, 0, 0});
    tbl.push_back('{0,  0, 0,  4, 0, 0,  4, 0, 0});
    tbl.push_back('{0,  0, 0,  3, 0, 0,  3, 0, 0});
    tbl.push_back('{0,  0, 0,  2, 0, 0,  2, 0, 0});
    tbl.push_back('{0,  0, 0,  1, 0, 0,  1, 0, 0});
    tbl.push_back('{0,  0, 0,  0, 1, 1,  5, 1, 0});
    tbl.push_back('{0,  0, 0,  0, 0, 1,  4, 0, 0});
    tbl.push_back('{0,  0, 1,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{1, 40, 0, 32, 0, 0, 32, 0, 0});
    tbl.push_back('{0,  0, 1,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{1,  0, 0,  0, 1, 1,  0, 1, 1});
    tbl.push_back('{0,  0, 0,  0, 0, 1,  0, 0, 1});
    tbl.push_back('{0,  0, 1,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{1,  6, 1,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{1,  3, 0,  3, 0, 0,  3, 0, 0});
    tbl.push_back('{0,  0, 0,  2, 0, 0,  2, 0, 0});
    tbl.push_back('{0,  0, 0,  1, 0, 0,  1, 0, 0});
    tbl.push_back('{0,  0, 1,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{0,  0, 0,  0, 0, 0,  0, 0, 0});
    tbl.push_back('{1,  2, 0,  2, 0, 0,  2, 0, 0});
    tbl.push_back('{1,  9, 0,  1, 0, 0,  1, 0, 0});
    tbl.push_back('{0,  0, 0,  0, 1, 1,  2, 1, 0});
    tbl.push_back('{0,  0, 1,  0, 0, 0,  0, 0, 0});

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[r]) begin
      ld_v = tbl[r].v;
      ld_val = 6'(tbl[r].val);
      ab = tbl[r].ab;
      tick();
      chk($sformatf("vec%0d cnt_os", r), int'(cnt0), tbl[r].c0);
      chk($sformatf("vec%0d done_os", r), int'(done0), int'(tbl[r].d0));
      chk($sformatf("vec%0d exp_os", r), int'(exp0), int'(tbl[r].e0));
      chk($sformatf("vec%0d cnt_lp", r), int'(cnt1), tbl[r].c1);
      chk($sformatf("vec%0d done_lp", r), int'(done1), int'(tbl[r].d1));
      chk($sformatf("vec%0d exp_lp", r), int'(exp1), int'(tbl[r].e1));
    end
    ld_v = 1'b0; ab = 1'b0;

    // Auto-reload with period 3; ready stays low throughout.
    ld_v = 1'b1; ld_val = 6'd3;
    tick();
    ld_v = 1'b0;
    chk("loop3 load cnt", int'(cnt1), 3);
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) begin ld_v = 1'b1; ld_val = 6'd7; end
      else ld_v = 1'b0;
      tick();
      chk($sformatf("loop3 k%0d cnt", k), int'(cnt1), 3 - (k % 3));
      chk($sformatf("loop3 k%0d done", k), int'(done1), int'(k % 3 == 0));
      chk($sformatf("loop3 k%0d rdy", k), int'(rdy1), 0);
    end
    ld_v = 1'b0;
    ab = 1'b1; tick(); ab = 1'b0;

    // Reset asserted mid-count at 7: outputs clear without a clock edge.
    ld_v = 1'b1; ld_val = 6'd9;
    tick();
    ld_v = 1'b0;
    tick(); tick();
    chk("midrst pre cnt_os", int'(cnt0), 7);
    chk("midrst pre cnt_lp", int'(cnt1), 7);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    #1 rst = 1'b1;
    ld_v = 1'b1; ld_val = 6'd4;
    tick();
    ld_v = 1'b0;
    chk("postrst load cnt_os", int'(cnt0), 4);
    chk("postrst load cnt_lp", int'(cnt1), 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_model($sformatf("postrst k%0d", k));
    end
    ab = 1'b1; tick(); ab = 1'b0;
    chk_model("postrst abort");

    // Randomized traffic checked against the reference.
    for (int n = 0; n < 600; n++) begin
      ld_v = ($urandom_range(0, 3) == 0);
      ld_val = 6'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) ld_val = 6'($urandom_range(0, 2));
      ab = ($urandom_range(0, 19) == 0);
      tick();
      chk_model($sformatf("rand%0d", n));
    end
    ld_v = 1'b0; ab = 1'b0;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
    // Pause for 3 edges at count 2 delays expiry by 3 cycles.
    ab = 1'b1; tick(); ab = 1'b0;
    ld_v = 1'b1; ld_val = 6'd4;
    tick();
    ld_v = 1'b0;
    tick(); tick();
    chk("pause pre cnt", int'(cnt0), 2);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pause hold%0d cnt", k), int'(cnt0), 2);
      chk($sformatf("pause hold%0d done", k), int'(done0), 0);
      chk($sformatf("pause hold%0d busy", k), int'(busy0), 1);
    end
    pause = 1'b0;
    tick();
    chk("pause resume cnt", int'(cnt0), 1);
    chk("pause resume done", int'(done0), 0);
    tick();
    chk("pause expiry cnt", int'(cnt0), 0);
    chk("pause expiry done", int'(done0), 1);
    chk("pause expiry exp", int'(exp0), 1);
    chk("pause expiry lp done", int'(done1), 1);
    chk("pause expiry lp cnt", int'(cnt1), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_CNT, default 32, largest loadable count value (>=1).
REQ-002 Parameter LOOP, default 1'b1, 1 = auto-reload on expiry, 0 = one-shot.
REQ-003 Local width W SHALL equal $clog2(MAX_CNT+1).
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous assert, active-low.
REQ-006 i_load_valid  input  1  load request.
REQ-007 i_load_val  input  W  count value to load.
REQ-008 o_load_ready  output  1  load accept; high in IDLE and DONE only.
REQ-009 i_abort  input  1  stop counting, return to IDLE.
REQ-010 o_cnt  output  W  current count value.
REQ-011 o_done  output  1  one-cycle expiry pulse.
REQ-012 o_busy  output  1  high in RUN.
REQ-013 o_expired  output  1  high in DONE.

Function
REQ-014 States IDLE, RUN, DONE; o_busy and o_expired decode state directly.
REQ-015 Load accepted on a rising edge where i_load_valid && o_load_ready; count <= i_load_val, reload register <= i_load_val, state <= RUN.
REQ-016 i_load_val > MAX_CNT SHALL saturate to MAX_CNT in both count and reload register.
REQ-017 Accepted i_load_val == 0: state <= DONE, o_done pulses next cycle, no reload even if LOOP=1.
REQ-018 RUN: count decrements by 1 each edge; no wrap below 0.
REQ-019 Expiry edge = RUN edge where count == 1; o_done is registered and high for exactly the following cycle.
REQ-020 Load of N accepted at edge k: o_cnt = N after edge k, o_done high after edge k+N (latency N cycles).
REQ-021 LOOP=0 expiry: count <= 0, state <= DONE; o_cnt holds 0 until next load.
REQ-022 LOOP=1 expiry: count <= reload register, stay RUN; o_done period exactly N cycles.
REQ-023 i_load_valid in RUN is ignored (ready low); no buffering.
REQ-024 i_abort in RUN or DONE: state <= IDLE, count <= 0, no o_done; abort has priority over expiry and load on the same edge.
REQ-025 i_abort in IDLE: no effect except blocking a same-edge load.

Reset
REQ-026 i_rst low SHALL immediately force state IDLE, count 0, reload register 0, o_done 0, o_busy 0, o_expired 0, o_load_ready 1.
REQ-027 Reset mid-RUN SHALL discard the count with no o_done pulse; first load accepted on the first edge after release.

Configuration
REQ-028 Macro COUNTDOWN_TIMER_PAUSE_EN, when defined, adds input i_pause (1 bit).
REQ-029 With macro: i_pause high in RUN freezes count and suppresses expiry; abort still honoured; no effect in IDLE/DONE.
REQ-030 Without macro: no i_pause port; counting never stalls.

Structure
REQ-031 Package countdown_timer_pkg SHALL hold the state typedef (IDLE/RUN/DONE encoding) and the width helper function.
REQ-032 No sub-module; single flat module.

Verification
REQ-033 Reset release, load 5, LOOP=0 -> o_cnt 5,4,3,2,1,0; o_done one cycle when o_cnt=0; o_expired high after.
REQ-034 LOOP=1, load 3 -> o_cnt 3,2,1,3,2,1...; o_done every 3 cycles; o_load_ready low throughout.
REQ-035 Load 40 with MAX_CNT=32 -> o_cnt 32; load 0 -> DONE, one o_done pulse, no reload.
REQ-036 i_abort on the same edge as count==1 -> IDLE, o_cnt 0, no o_done; load in RUN ignored.
REQ-037 i_rst low at o_cnt=7 -> all outputs at reset values without waiting for a clock edge; no o_done.
REQ-038 With COUNTDOWN_TIMER_PAUSE_EN, load 4, pause 3 cycles at o_cnt=2 -> o_cnt held 2, o_done delayed by 3 cycles.
